// File: rtl/ppg_afe_model.sv
// Behavioural model of the pulse-oximeter front end (photodiode, DC-comp DAC, PGA, 8-bit ADC).
// Produces heartbeat-modulated ADC codes that freeze for a settle window after any setting change.
module ppg_afe_model #(
    parameter int RED_DC   = 180,
    parameter int IR_DC    = 200,
    parameter int RED_AC   = 8,
    parameter int IR_AC    = 12,
    parameter int DARK     = 8,
    parameter int DC_STEP  = 4,
    parameter int PERIOD   = 100,
    parameter int SETTLE   = 3,
    parameter int CONV_DIV = 1,
    parameter int NOISE_EN = 0
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       LED_RED,
    input  logic       LED_IR,
    input  logic [6:0] DC_Comp,
    input  logic [3:0] PGA_Gain,
    output logic [7:0] ADC,
    output logic       ADC_valid,
    output logic       Settling,
    output logic       Beat,
    output logic       dbg_state
);

    typedef enum logic {TRACK = 1'b0, HOLD = 1'b1} state_t;

    localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [PW-1:0]      PH_LAST   = PW'(PERIOD - 1);
    localparam logic [PW-1:0]      PH_HALF   = PW'(PERIOD / 2);
    localparam logic signed [12:0] QUARTER   = 13'(PERIOD / 4);
    localparam logic signed [17:0] RED_DC_S  = 18'(RED_DC);
    localparam logic signed [17:0] IR_DC_S   = 18'(IR_DC);
    localparam logic signed [17:0] RED_AC_S  = 18'(RED_AC);
    localparam logic signed [17:0] IR_AC_S   = 18'(IR_AC);
    localparam logic signed [17:0] DARK_S    = 18'(DARK);
    localparam logic signed [17:0] DC_STEP_S = 18'(DC_STEP);
    localparam logic [3:0]         SETTLE_C  = 4'(SETTLE);
    localparam logic [3:0]         CONV_LAST = 4'(CONV_DIV - 1);

    state_t        state, state_nxt;
    logic [3:0]    settle_cnt, settle_nxt;
    logic [3:0]    conv_cnt;
    logic [PW-1:0] phase;
    logic [7:0]    lfsr;
    logic [12:0]   in_q, in_d;
    logic          chg, tick, do_conv;

    logic [PW-1:0]      w;
    logic signed [12:0] ac_raw, diff;
    logic signed [17:0] ac_red, ac_ir, pd, dc_sub, gain_s, amp, noise, y;
    logic [7:0]         y_clamped;

    assign in_d      = {LED_RED, LED_IR, DC_Comp, PGA_Gain};
    assign chg       = (in_d != in_q);
    assign tick      = (conv_cnt == CONV_LAST);
    assign Settling  = (settle_cnt != 4'd0);
    assign dbg_state = state;

    // Settle FSM: a change reloads the counter even mid-hold; conversions only in TRACK.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state      <= TRACK;
            settle_cnt <= 4'd0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_nxt;
        end
    end

    always_comb begin
        settle_nxt = settle_cnt;
        state_nxt  = state;
        do_conv    = 1'b0;
        if (chg)
            settle_nxt = SETTLE_C;
        else if (settle_cnt != 4'd0)
            settle_nxt = settle_cnt - 4'd1;
        state_nxt = (settle_nxt != 4'd0) ? HOLD : TRACK;
        // A change on the same edge as a tick suppresses the conversion.
        do_conv = tick && (settle_cnt == 4'd0) && !chg;
    end

    always_comb begin
        w      = (phase < PH_HALF) ? phase : (PH_LAST - phase);
        ac_raw = $signed({{(13-PW){1'b0}}, w}) - QUARTER;
        ac_red = (18'(ac_raw) * RED_AC_S) >>> 3;
        ac_ir  = (18'(ac_raw) * IR_AC_S) >>> 3;
        case ({in_q[12], in_q[11]})
            2'b10:   pd = RED_DC_S + ac_red;
            2'b01:   pd = IR_DC_S + ac_ir;
            2'b11:   pd = RED_DC_S + ac_red + IR_DC_S + ac_ir;
            default: pd = DARK_S;
        endcase
        dc_sub = DC_STEP_S * $signed({11'b0, in_q[10:4]});
        diff   = 13'(pd - dc_sub);
        gain_s = $signed({14'b0, in_q[3:0]}) + 18'sd1;
        amp    = 18'(diff) * gain_s;
        noise  = (NOISE_EN != 0) ? 18'($signed(lfsr[1:0])) : 18'sd0;
        y      = 18'sd128 + (amp >>> 2) + noise;
        if (y[17])
            y_clamped = 8'd0;
        else if (y > 18'sd255)
            y_clamped = 8'd255;
        else
            y_clamped = y[7:0];
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            in_q      <= '0;
            phase     <= '0;
            Beat      <= 1'b0;
            conv_cnt  <= 4'd0;
            lfsr      <= 8'hA5;
            ADC       <= 8'd128;
            ADC_valid <= 1'b0;
        end else begin
            in_q      <= in_d;
            phase     <= (phase == PH_LAST) ? '0 : phase + 1'b1;
            Beat      <= (phase == PH_LAST);
            conv_cnt  <= tick ? 4'd0 : conv_cnt + 4'd1;
            lfsr      <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            ADC_valid <= do_conv;
            if (do_conv)
                ADC <= y_clamped;
        end
    end

endmodule
